// File: rtl/ahb_slave_pkg.sv
// Shared types and constants for the AHB-lite memory responder.
package ahb_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } slave_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ are the only transfer types that carry data.
  function automatic logic is_active_trans(input htrans_t trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_sram.sv
// Word array behind the AHB responder: synchronous write, asynchronous read.
module ahb_slave_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory responder with configurable wait states.
// Define AHB_SLAVE_MEM_ERR_EN to enable the two-cycle ERROR response for illegal addresses.
module ahb_slave_mem
  import ahb_slave_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clock,
  input  logic                     HRESETn,
  input  logic                     HSELAHB,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  slave_state_t          r_state;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_hready;
  logic                  r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;

  htrans_t               w_trans;
  logic                  w_accept;
  logic                  w_illegal;
  slave_state_t          w_nxt_state;
  logic [3:0]            w_nxt_cnt;
  logic                  w_nxt_ready;
  logic                  w_nxt_resp;
  logic [DATA_WIDTH-1:0] w_nxt_rdata;
  logic                  w_we;
  logic [IDX_W-1:0]      w_haddr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_write;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_trans     = htrans_t'(HTRANS);
  assign w_accept    = HSELAHB && is_active_trans(w_trans) && r_hready;
  assign w_haddr_idx = HADDR[2 +: IDX_W];

`ifdef AHB_SLAVE_MEM_ERR_EN
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_DEPTH * 4);
  assign w_illegal = ({1'b0, HADDR} >= ADDR_LIMIT) || (HADDR[1:0] != 2'b00);
`else
  // Upper address bits and byte lane are ignored: addresses alias onto the array.
  logic w_unused_addr;
  assign w_illegal     = 1'b0;
  assign w_unused_addr = ^{HADDR[ADDRESS_WIDTH-1:IDX_W+2], HADDR[1:0], w_illegal};
`endif

  // Next-state, wait counter and next registered bus outputs.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_ready = 1'b1;
    w_nxt_resp  = HRESP_OKAY;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_nxt_state = ST_ACCESS;
        end else begin
          w_nxt_cnt   = r_cnt - 4'd1;
          w_nxt_ready = 1'b0;
        end
      end
`ifdef AHB_SLAVE_MEM_ERR_EN
      ST_ERR1: begin
        w_nxt_state = ST_ERR2;
        w_nxt_resp  = HRESP_ERROR;
      end
`endif
      default: begin
        if (!w_accept) begin
          w_nxt_state = ST_IDLE;
`ifdef AHB_SLAVE_MEM_ERR_EN
        end else if (w_illegal) begin
          w_nxt_state = ST_ERR1;
          w_nxt_ready = 1'b0;
          w_nxt_resp  = HRESP_ERROR;
`endif
        end else if (WAIT_STATES == 0) begin
          w_nxt_state = ST_ACCESS;
        end else begin
          w_nxt_state = ST_WAIT;
          w_nxt_cnt   = WAIT_LOAD;
          w_nxt_ready = 1'b0;
        end
      end
    endcase
  end

  // A back-to-back read of the word being written sees the committing data.
  assign w_we        = (r_state == ST_ACCESS) && r_write;
  assign w_rd_idx    = w_accept ? w_haddr_idx : r_idx;
  assign w_rd_write  = w_accept ? HWRITE : r_write;
  assign w_rd_data   = (w_we && (r_idx == w_rd_idx)) ? HWDATA : w_mem_rdata;
  assign w_nxt_rdata = ((w_nxt_state == ST_ACCESS) && !w_rd_write) ? w_rd_data : '0;

  // State, counter, captured address phase and registered outputs.
  always_ff @(posedge clock or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_hrdata <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_hready <= w_nxt_ready;
      r_hresp  <= w_nxt_resp;
      r_hrdata <= w_nxt_rdata;
      if (w_accept) begin
        r_idx   <= w_haddr_idx;
        r_write <= HWRITE;
      end
    end
  end

  ahb_slave_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (HWDATA),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  assign HREADY = r_hready;
  assign HRESP  = r_hresp;
  assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: three responders (1, 0 and 3 wait states) sharing one bus, one selected at a time.
module tb_ahb_slave_mem;
  import ahb_slave_pkg::*;

`ifdef AHB_SLAVE_MEM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic        hresp  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .clock(clk), .HRESETn(rst_n[0]), .HSELAHB(sel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .clock(clk), .HRESETn(rst_n[1]), .HSELAHB(sel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

  ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .clock(clk), .HRESETn(rst_n[2]), .HSELAHB(sel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]));

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  // Drive one cycle of bus inputs toward responder k, then land on the next falling edge.
  task automatic step(input int k, input logic s, input logic [1:0] t, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    sel    = 3'b000;
    sel[k] = s;
    htrans = t;
    hwrite = w;
    haddr  = a;
    hwdata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int k, input logic r, input logic p,
                       input logic [31:0] d);
    checks++;
    if (hready[k] !== r || hresp[k] !== p || hrdata[k] !== d) begin
      failures++;
      $display("FAIL %s: got HREADY=%0b HRESP=%0b HRDATA=%h, expected HREADY=%0b HRESP=%0b HRDATA=%h",
               name, hready[k], hresp[k], hrdata[k], r, p, d);
    end
  endtask

  initial begin
    logic [31:0] exp0;
    rst_n  = 3'b000;
    sel    = 3'b000;
    haddr  = 32'h0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hwdata = 32'h0;

    // Pipelined table for the zero-wait responder.
    vecs[0]  = '{1'b1, HTRANS_NONSEQ, 1'b1, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, HTRANS_NONSEQ, 1'b1, 32'h4,  32'h11111111, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, HTRANS_NONSEQ, 1'b1, 32'h8,  32'h22222222, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, HTRANS_NONSEQ, 1'b0, 32'h0,  32'h33333333, 1'b1, 1'b0, 32'h11111111};
    vecs[4]  = '{1'b1, HTRANS_SEQ,    1'b0, 32'h4,  32'h0,        1'b1, 1'b0, 32'h22222222};
    vecs[5]  = '{1'b1, HTRANS_SEQ,    1'b0, 32'h8,  32'h0,        1'b1, 1'b0, 32'h33333333};
    vecs[6]  = '{1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, HTRANS_BUSY,   1'b1, 32'h4,  32'h00000BAD, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, HTRANS_IDLE,   1'b1, 32'h4,  32'h00000BAD, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, HTRANS_NONSEQ, 1'b1, 32'h4,  32'h00000BAD, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h00000BAD, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b1, HTRANS_NONSEQ, 1'b0, 32'h4,  32'h0,        1'b1, 1'b0, 32'h22222222};
    vecs[12] = '{1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, HTRANS_NONSEQ, 1'b1, 32'hC,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, HTRANS_NONSEQ, 1'b0, 32'hC,  32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b1, HTRANS_SEQ,    1'b0, 32'hC,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[16] = '{1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};

    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset_k%0d", k), k, 1'b1, 1'b0, 32'h0);
    rst_n = 3'b111;
    @(negedge clk);

    // One wait state: write then pipelined read of 0x10.
    step(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, 32'h0);        check("ws1_wr_wait",   0, 1'b0, 1'b0, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'hFFFF0000); check("ws1_wr_access", 0, 1'b1, 1'b0, 32'h0);
    step(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, 32'hDEADBEEF); check("ws1_rd_wait",   0, 1'b0, 1'b0, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws1_rd_data",   0, 1'b1, 1'b0, 32'hDEADBEEF);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws1_idle",      0, 1'b1, 1'b0, 32'h0);

    // Seed word 0, then an out-of-range write to 0x400.
    step(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0, 32'hA5A5A5A5);
    step(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h400, 32'h0);       check("oor_wr_p1", 0, 1'b0, ERR_EN, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,   32'h55);      check("oor_wr_p2", 0, 1'b1, ERR_EN, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,   32'h55);      check("oor_wr_p3", 0, 1'b1, 1'b0, 32'h0);
    exp0 = ERR_EN ? 32'hA5A5A5A5 : 32'h00000055;
    step(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, 32'h0);         check("rd0_wait",  0, 1'b0, 1'b0, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0, 32'h0);         check("rd0_data",  0, 1'b1, 1'b0, exp0);

    // Misaligned read of 0x2.
    step(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h2, 32'h0);         check("mis_p1",    0, 1'b0, ERR_EN, 32'h0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0, 32'h0);         check("mis_p2",    0, 1'b1, ERR_EN, ERR_EN ? 32'h0 : exp0);
    step(0, 1'b1, HTRANS_IDLE,   1'b0, 32'h0, 32'h0);         check("mis_p3",    0, 1'b1, 1'b0, 32'h0);

    // Zero wait states, table driven.
    for (int i = 0; i < NVEC; i++) begin
      step(1, vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d", i), 1, vecs[i].exp_ready, vecs[i].exp_resp, vecs[i].exp_rdata);
    end

    // Three wait states: commit old value to 0x20, then reset in the middle of a new write.
    step(2, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h20, 32'h0);        check("ws3_w1", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws3_w2", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws3_w3", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws3_w4", 2, 1'b1, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0BADF00D); check("ws3_w5", 2, 1'b1, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h20, 32'h0);        check("ws3_n1", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("ws3_n2", 2, 1'b0, 1'b0, 32'h0);
    rst_n[2] = 1'b0;
    #1;
    check("rst_mid_async", 2, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_hold", 2, 1'b1, 1'b0, 32'h0);
    rst_n[2] = 1'b1;
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("rst_post1", 2, 1'b1, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("rst_post2", 2, 1'b1, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, 32'h12345678); check("ws3_r1", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("ws3_r2", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("ws3_r3", 2, 1'b0, 1'b0, 32'h0);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h12345678); check("ws3_r4", 2, 1'b1, 1'b0, 32'h0BADF00D);
    step(2, 1'b1, HTRANS_IDLE,   1'b0, 32'h0,  32'h0);        check("ws3_r5", 2, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
